// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means classification sequencer.
// State encoding, pipeline depth constants and default widths.
package kmeans_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CENT,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } classify_state_t;

  localparam int RAM_RD_LATENCY      = 1;
  localparam int CLASSIFY_PIPE_DEPTH = 2;

  localparam int ADDR_WIDTH   = 8;
  localparam int COUNT_WIDTH  = 10;
  localparam int CENTROID_NUM = 8;

endpackage

// File: rtl/classify_ctrl_if.sv
// Control/status bundle between classify_ctrl and the k-means datapath.
// master: sequencer side (drives strobes, tags, status); slave: host/datapath.
interface classify_ctrl_if #(
  parameter int AW = 8,
  parameter int CN = 8,
  parameter int CW = 10
) ();

  logic          start;
  logic          abort;
  logic [AW:0]   num_points;
  logic [CN-1:0] centroid_en;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic          input_reg_en;
  logic          dist_valid;
  logic [AW-1:0] dist_index;
  logic [CW-1:0] point_count;
  logic          busy;
  logic          done;

  modport master (
    input  start,
    input  abort,
    input  num_points,
    output centroid_en,
    output ram_rd_en,
    output ram_addr,
    output input_reg_en,
    output dist_valid,
    output dist_index,
    output point_count,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output num_points,
    input  centroid_en,
    input  ram_rd_en,
    input  ram_addr,
    input  input_reg_en,
    input  dist_valid,
    input  dist_index,
    input  point_count,
    input  busy,
    input  done
  );

endinterface

// File: rtl/classify_valid_pipe.sv
// Two-stage {valid, index} shift register tagging points through the datapath.
// Ports: in_valid/in_index (RAM read), s1_valid (input reg load), s2_* (dist tag).
module classify_valid_pipe
  import kmeans_pkg::*;
#(
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_index,
  output logic          s1_valid,
  output logic          s2_valid,
  output logic [AW-1:0] s2_index
);

  logic [AW-1:0] s1_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_index <= '0;
      s2_valid <= 1'b0;
      s2_index <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_index <= '0;
      s2_valid <= 1'b0;
      s2_index <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_index <= in_index;
      s2_valid <= s1_valid;
      s2_index <= s1_index;
    end
  end

endmodule

// File: rtl/classify_ctrl.sv
// Sequencer for k-means classification: centroid load, point streaming, drain.
// Ports: clk, rst_n, bus (start/abort/num_points in; strobes, tags, status out).
module classify_ctrl
  import kmeans_pkg::*;
#(
  parameter int addrWidth    = ADDR_WIDTH,
  parameter int centroid_num = CENTROID_NUM,
  parameter int count_width  = COUNT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  classify_ctrl_if.master bus
);

  localparam int NW = addrWidth + 1;

  classify_state_t state_q, state_d;

  logic [NW-1:0]           n_q, n_d;
  logic [addrWidth-1:0]    addr_q, addr_d;
  logic [count_width-1:0]  cnt_q, cnt_d;
  logic [centroid_num-1:0] cent_q, cent_d;
  logic                    rd_q, rd_d;
  logic                    done_q, done_d;

  logic                    ire;
  logic                    dv;
  logic [addrWidth-1:0]    didx;
  logic                    kill;
  logic                    accept;
  logic                    last;

  assign kill   = bus.abort && (state_q != S_IDLE);
  assign accept = bus.start && !bus.abort;

  // Compare in NW bits so a full 2^addrWidth run ends at all-ones
  assign last = (({1'b0, addr_q}) + NW'(1)) == n_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;

    if (dv) cnt_d = cnt_q + count_width'(1);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          n_d     = bus.num_points;
          cnt_d   = '0;
          state_d = S_LOAD_CENT;
        end
      end
      S_LOAD_CENT: begin
        addr_d  = '0;
        state_d = (n_q != '0) ? S_FETCH : S_DONE;
      end
      S_FETCH: begin
        if (last) state_d = S_DRAIN;
        else      addr_d  = addr_q + addrWidth'(1);
      end
      S_DRAIN: begin
        // Stage bits one cycle ahead: next s1 = rd_q, next s2 = ire
        if (!rd_q && !ire) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (kill) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
    end
  end

  // Registered outputs decoded from the next state
  always_comb begin
    cent_d = '0;
    rd_d   = 1'b0;
    done_d = 1'b0;
    unique case (1'b1)
      (state_d == S_LOAD_CENT): cent_d = '1;
      (state_d == S_FETCH):     rd_d   = 1'b1;
      (state_d == S_DONE):      done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      cent_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cent_q  <= cent_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  classify_valid_pipe #(
    .AW (addrWidth)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (kill),
    .in_valid (rd_q),
    .in_index (addr_q),
    .s1_valid (ire),
    .s2_valid (dv),
    .s2_index (didx)
  );

  assign bus.centroid_en  = cent_q;
  assign bus.ram_rd_en    = rd_q;
  assign bus.ram_addr     = addr_q;
  assign bus.input_reg_en = ire;
  assign bus.dist_valid   = dv;
  assign bus.dist_index   = didx;
  assign bus.point_count  = cnt_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_classify_ctrl.sv
// Self-checking bench for classify_ctrl against a cycle-offset timing model.
// Directed runs plus randomized lengths/aborts; one summary line at the end.
module tb_classify_ctrl;

  localparam int AW = 8;
  localparam int CN = 8;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  classify_ctrl_if #(.AW(AW), .CN(CN), .CW(CW)) bus ();

  classify_ctrl #(
    .addrWidth    (AW),
    .centroid_num (CN),
    .count_width  (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, " cent"}, 32'(bus.centroid_en), 0);
    chk({tag, " rd"},   32'(bus.ram_rd_en), 0);
    chk({tag, " addr"}, 32'(bus.ram_addr), 0);
    chk({tag, " ire"},  32'(bus.input_reg_en), 0);
    chk({tag, " dv"},   32'(bus.dist_valid), 0);
    chk({tag, " idx"},  32'(bus.dist_index), 0);
    chk({tag, " cnt"},  32'(bus.point_count), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
  endtask

  // Cycle k counts from the cycle in which start is high (k=0).
  // abort_at/glitch_at/reset_at < 0 disables that event.
  task automatic run(input int n, input int abort_at,
                     input int glitch_at, input int reset_at);
    int  done_k;
    int  kk;
    int  ecnt;
    bit  act;
    done_k = (n == 0) ? 2 : 4 + n;
    @(negedge clk);
    chk("pre busy", 32'(bus.busy), 0);
    bus.start      = 1'b1;
    bus.num_points = n[AW:0];
    for (int k = 1; k <= done_k + 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        all_zero("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      act  = (abort_at < 0) || (k <= abort_at);
      kk   = act ? k : abort_at;
      ecnt = clamp(kk - 4, 0, n);
      chk($sformatf("n=%0d k=%0d cent", n, k), 32'(bus.centroid_en),
          (act && k == 1) ? 32'hFF : 32'h0);
      chk($sformatf("n=%0d k=%0d rd", n, k), 32'(bus.ram_rd_en),
          32'(act && k >= 2 && k < 2 + n));
      if (act && k >= 2 && k < 2 + n)
        chk($sformatf("n=%0d k=%0d addr", n, k), 32'(bus.ram_addr),
            32'(k - 2));
      if (act && n > 0 && k >= 2 + n && k <= done_k)
        chk($sformatf("n=%0d k=%0d addr hold", n, k), 32'(bus.ram_addr),
            32'(n - 1));
      chk($sformatf("n=%0d k=%0d ire", n, k), 32'(bus.input_reg_en),
          32'(act && k >= 3 && k < 3 + n));
      chk($sformatf("n=%0d k=%0d dv", n, k), 32'(bus.dist_valid),
          32'(act && k >= 4 && k < 4 + n));
      if (act && k >= 4 && k < 4 + n)
        chk($sformatf("n=%0d k=%0d idx", n, k), 32'(bus.dist_index),
            32'(k - 4));
      chk($sformatf("n=%0d k=%0d cnt", n, k), 32'(bus.point_count),
          32'(ecnt));
      chk($sformatf("n=%0d k=%0d done", n, k), 32'(bus.done),
          32'(act && k == done_k));
      chk($sformatf("n=%0d k=%0d busy", n, k), 32'(bus.busy),
          32'(act && k <= done_k));
      if (k == abort_at) bus.abort = 1'b1;
      if (k == glitch_at) begin
        bus.start      = 1'b1;
        bus.num_points = 9'd3;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    int n;
    int ab;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.num_points = '0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;

    run(4, -1, -1, -1);
    run(0, -1, -1, -1);
    run(256, -1, -1, -1);
    run(10, 4, -1, -1);
    run(6, -1, 3, -1);
    run(10, -1, -1, 5);
    run(2, -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      n  = int'($urandom_range(0, 40));
      ab = -1;
      if ($urandom_range(0, 1) == 1)
        ab = int'($urandom_range(1, (n == 0) ? 1 : 3 + n));
      run(n, ab, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/classify_ctrl.md
Name: classify_ctrl

Overview:
- Sequencer for the k-means classification datapath (centroid registers + input register + 8 distance calculators).
- On start: loads all centroid registers in one cycle, then streams points from point RAM at one per cycle.
- Produces a valid/index tag aligned with the combinational distance outputs, so the downstream min-select/accumulate stage knows which point each distance set belongs to.
- Signals done after the pipeline drains.

Parameters:
- addrWidth, 8, point RAM address width; max points = 2^addrWidth.
- centroid_num, 8, number of centroid registers; width of centroid_en.
- count_width, 10, width of point_count; must be >= addrWidth+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE, no done.
- num_points  input  addrWidth+1  points to classify; sampled on accepted start.
- centroid_en  output  centroid_num  centroid register load enables.
- ram_rd_en  output  1  point RAM read strobe.
- ram_addr  output  addrWidth  point RAM read address.
- input_reg_en  output  1  input register load enable.
- dist_valid  output  1  distance outputs valid this cycle.
- dist_index  output  addrWidth  RAM index of the point whose distances are valid.
- point_count  output  count_width  points classified since the last accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. On reset all outputs are 0, state is IDLE, and the internal count and address registers are 0.
- All outputs are registered except busy, which is decoded from state.
- RAM read latency is fixed at 1 cycle: data for an address issued in cycle t is on data_from_ram in cycle t+1.
- States: IDLE, LOAD_CENT, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 latches num_points into n_lat, clears point_count and moves to LOAD_CENT.
  - start while busy is ignored.
- LOAD_CENT (1 cycle):
  - centroid_en = all ones for exactly this cycle.
  - Next state is FETCH if n_lat>0; if n_lat==0, DONE.
  - Centroid inputs must be stable when start is issued.
- FETCH:
  - ram_rd_en=1 with ram_addr = 0,1,...,n_lat-1, one address per cycle, no gaps.
  - After the address n_lat-1 cycle, go to DRAIN.
- Input register timing: input_reg_en is ram_rd_en delayed 1 cycle.
- Distance tag timing:
  - dist_valid is ram_rd_en delayed 2 cycles.
  - dist_index is ram_addr delayed 2 cycles.
  - Net timing: address issued in cycle t, input register loaded at the end of t+1, distances valid in t+2.
- point_count increments on every dist_valid cycle.
- DRAIN: stay until both pipeline valid bits (the input_reg_en and dist_valid stages) are 0, then go to DONE.
- DONE (1 cycle): done=1, then IDLE. point_count holds its value until the next accepted start.
- num_points = 2^addrWidth: ram_addr reaches all-ones and stops there. There is no wrap, and the comparison uses the addrWidth+1 counter.
- abort:
  - Takes effect in any non-IDLE state.
  - Next cycle: state IDLE; ram_rd_en, input_reg_en, dist_valid and centroid_en all 0; no done pulse; point_count frozen.
  - abort has priority over start in the same cycle.
- Reset mid-operation: outputs return to their reset values immediately (asynchronous); no done pulse.

Decomposition:
- Shared package (kmeans_pkg):
  - state enum type classify_state_t.
  - constants RAM_RD_LATENCY=1 and CLASSIFY_PIPE_DEPTH=2.
  - default widths ADDR_WIDTH and COUNT_WIDTH.
- Sub-module classify_valid_pipe: a 2-stage shift register carrying {valid, index}, used to generate input_reg_en, dist_valid and dist_index.
- FSM and counters stay in classify_ctrl.

Test Plan:
- Reset → all outputs 0, busy=0; start with num_points=4 →
  - centroid_en=8'hFF for 1 cycle.
  - ram_addr 0,1,2,3 on 4 consecutive cycles.
  - dist_valid high 4 cycles starting 2 cycles after the first read, dist_index 0..3.
  - done pulse 1 cycle after the last dist_valid; point_count=4.
- num_points=0 → LOAD_CENT then done 2 cycles after start; no ram_rd_en, point_count=0.
- num_points=256 → addresses 0..255 contiguous, ram_addr never wraps; point_count=256, then done.
- abort on the 3rd FETCH cycle with num_points=10 → IDLE next cycle, all strobes 0 within 1 cycle, no done, point_count frozen at its value when abort was sampled.
- start pulsed again during FETCH → ignored: address sequence and point_count unaffected.
- rst_n asserted mid-FETCH → outputs 0 asynchronously. After release, start with num_points=2 → clean run, point_count=2.
